// File: rtl/digits_to_byte.sv
// Accumulates MSD-first BCD digits into a 16-bit value; one-cycle result pulse on commit.
// Define DIGITS_TO_BYTE_SATURATE_EN to clamp overflowing numbers to 16'hFFFF instead of wrapping.
module digits_to_byte (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  din,
  input  logic        wen,
  input  logic        commit,
  input  logic        clear,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic        overflow,
  output logic        digit_err,
  output logic        receiving
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t      state_q;
  logic [15:0] acc_q, acc_d;
  logic        ovf_q, ovf_d;
  logic [15:0] dout_q;
  logic        dout_valid_q, overflow_q, digit_err_q;

  logic [19:0] next_w;
  logic        digit_ok;
  logic        too_big;
  logic        commit_ok;

  // acc*10 + din without a multiplier; 20 bits holds the worst case 655359
  assign next_w   = {1'b0, acc_q, 3'b000} + {3'b000, acc_q, 1'b0} + {16'd0, din};
  assign digit_ok = wen && (din <= 4'd9);
  assign too_big  = |next_w[19:16];
  // A digit accepted this cycle makes an empty number committable in the same cycle
  assign commit_ok = commit && ((state_q == ACCUM) || digit_ok);

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (digit_ok) begin
      ovf_d = ovf_q | too_big;
`ifdef DIGITS_TO_BYTE_SATURATE_EN
      acc_d = too_big ? 16'hFFFF : next_w[15:0];
`else
      acc_d = next_w[15:0];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= 16'd0;
      ovf_q        <= 1'b0;
      dout_q       <= 16'd0;
      overflow_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      digit_err_q  <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      digit_err_q  <= 1'b0;
      if (clear) begin
        state_q <= IDLE;
        acc_q   <= 16'd0;
        ovf_q   <= 1'b0;
      end else begin
        digit_err_q <= wen && !digit_ok;
        if (commit_ok) begin
          dout_q       <= acc_d;
          overflow_q   <= ovf_d;
          dout_valid_q <= 1'b1;
          acc_q        <= 16'd0;
          ovf_q        <= 1'b0;
          state_q      <= IDLE;
        end else if (digit_ok) begin
          acc_q   <= acc_d;
          ovf_q   <= ovf_d;
          state_q <= ACCUM;
        end
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overflow   = overflow_q;
  assign digit_err  = digit_err_q;
  assign receiving  = (state_q == ACCUM);

endmodule

// File: tb/tb_digits_to_byte.sv
// Scoreboard bench for digits_to_byte: expected results queued at commit, checked on dout_valid.
module tb_digits_to_byte;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  din = 4'd0;
  logic        wen = 1'b0;
  logic        commit = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic        overflow;
  logic        digit_err;
  logic        receiving;

  typedef struct packed {
    logic [15:0] val;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   err_cnt = 0;
  int   pulse_cnt = 0;
  int   err_base;

  digits_to_byte dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .wen        (wen),
    .commit     (commit),
    .clear      (clear),
    .dout       (dout),
    .dout_valid (dout_valid),
    .overflow   (overflow),
    .digit_err  (digit_err),
    .receiving  (receiving)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; inputs change 1 ns after the rising edge
  task automatic cyc(input logic [3:0] d, input logic w, input logic c, input logic cl);
    din    = d;
    wen    = w;
    commit = c;
    clear  = cl;
    @(posedge clk);
    #1;
    din    = 4'd0;
    wen    = 1'b0;
    commit = 1'b0;
    clear  = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] v, input logic o);
    exp_t e;
    e.val = v;
    e.ovf = o;
    sb_q.push_back(e);
  endtask

  task automatic send_digits(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                             input logic [3:0] d3, input logic [3:0] d4, input int n);
    logic [3:0] ds [5];
    ds[0] = d0; ds[1] = d1; ds[2] = d2; ds[3] = d3; ds[4] = d4;
    for (int i = 0; i < n; i++) cyc(ds[i], 1'b1, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (digit_err === 1'b1) err_cnt++;
      if (dout_valid === 1'b1) begin
        exp_t e;
        pulse_cnt++;
        if (sb_q.size() == 0) begin
          chk("spurious_pulse", 32'(dout_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("dout", 32'(dout), 32'(e.val));
          chk("overflow", 32'(overflow), 32'(e.ovf));
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_err", 32'(digit_err), 32'd0);
    chk("rst_recv", 32'(receiving), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1,2,3 then commit
    cyc(4'd1, 1'b1, 1'b0, 1'b0);
    chk("recv_first_digit", 32'(receiving), 32'd1);
    send_digits(4'd2, 4'd3, 4'd0, 4'd0, 4'd0, 2);
    chk("recv_before_commit", 32'(receiving), 32'd1);
    push_exp(16'd123, 1'b0);
    cyc(4'd0, 1'b0, 1'b1, 1'b0);
    chk("recv_after_commit", 32'(receiving), 32'd0);

    // exact maximum
    send_digits(4'd6, 4'd5, 4'd5, 4'd3, 4'd5, 5);
    push_exp(16'd65535, 1'b0);
    cyc(4'd0, 1'b0, 1'b1, 1'b0);

    // one past maximum
    send_digits(4'd6, 4'd5, 4'd5, 4'd3, 4'd6, 5);
`ifdef DIGITS_TO_BYTE_SATURATE_EN
    push_exp(16'd65535, 1'b1);
`else
    push_exp(16'd0, 1'b1);
`endif
    cyc(4'd0, 1'b0, 1'b1, 1'b0);

    // rejected digit in the middle
    err_base = err_cnt;
    send_digits(4'd4, 4'hA, 4'd2, 4'd0, 4'd0, 3);
    push_exp(16'd42, 1'b0);
    cyc(4'd0, 1'b0, 1'b1, 1'b0);
    chk("digit_err_count", 32'(err_cnt - err_base), 32'd1);

    // rejected digit alone does not make IDLE committable
    cyc(4'hF, 1'b1, 1'b1, 1'b0);
    chk("bad_digit_commit_recv", 32'(receiving), 32'd0);

    // leading zeros
    send_digits(4'd0, 4'd0, 4'd7, 4'd0, 4'd0, 3);
    push_exp(16'd7, 1'b0);
    cyc(4'd0, 1'b0, 1'b1, 1'b0);

    // digit and commit together, then empty commit
    push_exp(16'd9, 1'b0);
    cyc(4'd9, 1'b1, 1'b1, 1'b0);
    cyc(4'd0, 1'b0, 1'b1, 1'b0);
    chk("idle_commit_dout", 32'(dout), 32'd9);
    chk("idle_commit_valid", 32'(dout_valid), 32'd0);

    // back-to-back single-digit commits
    push_exp(16'd1, 1'b0);
    cyc(4'd1, 1'b1, 1'b1, 1'b0);
    push_exp(16'd2, 1'b0);
    cyc(4'd2, 1'b1, 1'b1, 1'b0);

    // clear discards 77
    send_digits(4'd7, 4'd7, 4'd0, 4'd0, 4'd0, 2);
    cyc(4'd3, 1'b1, 1'b1, 1'b1);
    chk("clear_recv", 32'(receiving), 32'd0);
    chk("clear_dout_held", 32'(dout), 32'd2);
    push_exp(16'd5, 1'b0);
    cyc(4'd5, 1'b1, 1'b0, 1'b0);
    cyc(4'd0, 1'b0, 1'b1, 1'b0);

    // asynchronous reset mid-number
    send_digits(4'd7, 4'd7, 4'd0, 4'd0, 4'd0, 2);
    rst = 1'b1;
    #2;
    chk("arst_recv", 32'(receiving), 32'd0);
    chk("arst_dout", 32'(dout), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    push_exp(16'd5, 1'b0);
    cyc(4'd5, 1'b1, 1'b0, 1'b0);
    cyc(4'd0, 1'b0, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("pulse_count", 32'(pulse_cnt), 32'd10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/digits_to_byte.md
# digits_to_byte

Decimal-digit-to-binary decoder that accumulates a stream of BCD digits, most significant digit first, into a 16-bit unsigned value. It is the inverse of `byte_to_digits`. It sits on the receive side of the RPN calculator, between the UART ASCII-to-digit stage and the operand stack. Each committed number is presented once as a one-cycle result pulse with an overflow flag.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  in  4  digit value, sampled when `wen`=1.
- `wen`  in  1  digit strobe; one digit is consumed per cycle it is high.
- `commit`  in  1  end-of-number strobe, for example on a space or operator.
- `clear`  in  1  abort the current number without output.
- `dout`  out  16  last committed value; held until the next commit.
- `dout_valid`  out  1  one-cycle pulse when `dout` is updated.
- `overflow`  out  1  qualifies `dout`; 1 if the committed number exceeded 65535.
- `digit_err`  out  1  one-cycle pulse when a digit > 9 is rejected.
- `receiving`  out  1  1 while at least one digit of a number has been accepted.

## Operation
- State machine states:
  - IDLE: no digits held.
  - ACCUM: one or more digits held.
- Internal registers: 16-bit accumulator `acc`, sticky `ovf`.
- Digit accepted (`wen`=1, `din`<=9):
  - Compute `next` = `acc`*10 + `din` in 20 bits, as (`acc`<<3)+(`acc`<<1)+`din`. The maximum is 655359, so 20 bits cannot overflow.
  - If `next` > 65535, set `ovf`. Per Configuration, `acc` takes the wrapped `next[15:0]` or the saturated value.
  - Otherwise `acc`=`next[15:0]`.
  - State becomes ACCUM.
- Rejected digit (`wen`=1, `din`>9):
  - `acc`, `ovf` and state are unchanged.
  - `digit_err` pulses the next cycle.
- Leading zeros are accepted and do not change the value: 0,0,7 yields 7.
- `commit` in ACCUM:
  - Update `dout` with the accumulated value, `overflow` with `ovf`, and pulse `dout_valid`.
  - Zero `acc` and `ovf`; go to IDLE.
- `commit` in IDLE (empty number) is ignored: no pulse, and `dout` is unchanged.
- `wen` and `commit` in the same cycle: the digit is folded in first and the result includes it. An accepted digit makes IDLE commit-eligible in that same cycle. A rejected digit does not.
- `clear` has the highest priority over `wen` and `commit`. It zeros `acc` and `ovf`, goes to IDLE, and produces no output. `dout` and `overflow` keep their last values.
- `receiving` = (state == ACCUM).

## Timing
- Reset values:
  - State IDLE.
  - `acc`=0, `ovf`=0.
  - `dout`=16'd0, `overflow`=0.
  - `dout_valid`=0, `digit_err`=0, `receiving`=0.
- Asserting `rst` mid-number discards the number immediately, asynchronously. No pulse is emitted.
- Digit throughput is one per cycle, with no stall and no backpressure.
- Latency: `commit` sampled at edge N gives `dout`, `overflow` and `dout_valid`=1 valid after edge N, for exactly one cycle.
- A new number's digits may arrive in the cycle right after `commit`. Back-to-back commits each produce their own pulse.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `DIGITS_TO_BYTE_SATURATE_EN` defined:
  - On overflow, `acc` is forced to 16'hFFFF and stays there for further digits in the same number.
  - The committed `dout` is 65535 with `overflow`=1.
- Undefined (default):
  - `acc` wraps: `acc`=`next[15:0]` on every digit.
  - The committed `dout` is the value mod 65536 after each step, with `overflow`=1.
- `overflow` behaviour is identical in both builds.

## Test plan
- Reset, then digits 1,2,3 at one per cycle with `commit` in the cycle after the 3 -> `dout`=123, `overflow`=0, one `dout_valid` pulse. `receiving` is high from the first digit until the commit.
- Digits 6,5,5,3,5, then commit -> `dout`=65535, `overflow`=0.
- Digits 6,5,5,3,6, then commit:
  - Default build -> `dout`=0, `overflow`=1.
  - SATURATE build -> `dout`=65535, `overflow`=1.
- Digits 4, 0xA, 2, then commit -> `digit_err` pulses once, `dout`=42.
- Digit 9 with `commit` in the same cycle -> `dout`=9. A following `commit` alone while IDLE produces no pulse, and `dout` stays 9.
- Digits 7,7, then `rst` pulse (or `clear`), then digit 5 and commit -> `dout`=5, with no output for the discarded 77.
